uart_rx: RTL and testbench

- UART receiver for 8N1 frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), idle line high.
- Oversamples the asynchronous serial input with the system clock at a fixed CLKS_PER_BIT ratio and samples each bit at its midpoint.
- Delivers the received byte with a sticky data-available flag.
- Sits at the serial-input edge of the design, feeding command/data parsers.
- Default CLKS_PER_BIT = 5208 gives 9600 baud from a 50 MHz clock.

---
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the serial line at CLKS_PER_BIT clocks per bit,
// samples each bit at its midpoint and presents the byte with sticky status flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic       o_data_available,
  output logic [7:0] o_data_byte,
  output logic       o_frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          avail_n, ferr_n;
  logic [7:0]    byte_n;

  assign rx_s = sync[1];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync             <= 2'b11;
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      shift            <= '0;
      o_data_available <= 1'b0;
      o_data_byte      <= 8'h00;
      o_frame_error    <= 1'b0;
    end else begin
      sync             <= {sync[0], i_rx};
      state            <= state_n;
      cnt              <= cnt_n;
      bit_idx          <= bit_idx_n;
      shift            <= shift_n;
      o_data_available <= avail_n;
      o_data_byte      <= byte_n;
      o_frame_error    <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    avail_n   = o_data_available;
    byte_n    = o_data_byte;
    ferr_n    = o_frame_error;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // A line still high at the start-bit midpoint was only a glitch.
        if (cnt == HALF_CNT) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
            avail_n   = 1'b0;
            ferr_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_n   = STOP;
            bit_idx_n = '0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        // Re-arming at the stop midpoint lets gapless back-to-back frames through.
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            byte_n  = shift;
            avail_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (16 clocks/bit) for most scenarios
// and a default-rate instance (5208 clocks/bit) for one full-speed byte.
module tb_uart_rx;

  localparam int CPB_A = 16;
  localparam int CPB_B = 5208;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       avail_a, ferr_a, avail_b, ferr_b;
  logic [7:0] byte_a, byte_b;

  int total = 0;
  int passed = 0;

  always #10 clock = ~clock;

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .i_clock(clock), .i_reset(i_reset), .i_rx(rx_a),
    .o_data_available(avail_a), .o_data_byte(byte_a), .o_frame_error(ferr_a));

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .i_clock(clock), .i_reset(i_reset), .i_rx(rx_b),
    .o_data_available(avail_b), .o_data_byte(byte_b), .o_frame_error(ferr_b));

  task automatic set_line(input bit on_b, input logic v);
    if (on_b) rx_b = v;
    else rx_a = v;
  endtask

  // Full frame: start, 8 data bits LSB first, stop bit of the requested level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb, input bit on_b);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(on_b, bits[i]);
      repeat (cpb) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    i_reset = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(negedge clock);
    i_reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (avail_a !== 1'b0) $display("[TB] FAIL reset_avail got %b want 0", avail_a); else passed++;
      total++; if (byte_a !== 8'h00) $display("[TB] FAIL reset_byte got %h want 00", byte_a); else passed++;
      total++; if (ferr_a !== 1'b0) $display("[TB] FAIL reset_ferr got %b want 0", ferr_a); else passed++;
      repeat (50) @(negedge clock);
    end
  endtask

  task automatic test_single_default_rate();
    send_frame(8'hAA, 1'b1, CPB_B, 1'b1);
    repeat (10) @(negedge clock);
    total++; if (avail_b !== 1'b1) $display("[TB] FAIL single_avail got %b want 1", avail_b); else passed++;
    total++; if (byte_b !== 8'hAA) $display("[TB] FAIL single_byte got %h want aa", byte_b); else passed++;
    total++; if (ferr_b !== 1'b0) $display("[TB] FAIL single_ferr got %b want 0", ferr_b); else passed++;
  endtask

  task automatic test_consecutive();
    logic [9:0] bits;
    logic [7:0] b2b [3];
    send_frame(8'hAA, 1'b1, CPB_A, 1'b0);
    total++; if (avail_a !== 1'b1) $display("[TB] FAIL aa_avail got %b want 1", avail_a); else passed++;
    total++; if (byte_a !== 8'hAA) $display("[TB] FAIL aa_byte got %h want aa", byte_a); else passed++;
    // 0xBB with the flag watched either side of its start-bit midpoint.
    bits = {1'b1, 8'hBB, 1'b0};
    set_line(1'b0, 1'b0);
    repeat (5) @(negedge clock);
    total++; if (avail_a !== 1'b1) $display("[TB] FAIL bb_pre_mid_avail got %b want 1", avail_a); else passed++;
    repeat (CPB_A - 5) @(negedge clock);
    total++; if (avail_a !== 1'b0) $display("[TB] FAIL bb_post_mid_avail got %b want 0", avail_a); else passed++;
    for (int i = 1; i < 10; i++) begin
      set_line(1'b0, bits[i]);
      repeat (CPB_A) @(negedge clock);
    end
    total++; if (avail_a !== 1'b1) $display("[TB] FAIL bb_avail got %b want 1", avail_a); else passed++;
    total++; if (byte_a !== 8'hBB) $display("[TB] FAIL bb_byte got %h want bb", byte_a); else passed++;
    b2b[0] = 8'h55;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h00;
    for (int f = 0; f < 3; f++) begin
      send_frame(b2b[f], 1'b1, CPB_A, 1'b0);
      total++; if (avail_a !== 1'b1) $display("[TB] FAIL b2b%0d_avail got %b want 1", f, avail_a); else passed++;
      total++; if (byte_a !== b2b[f]) $display("[TB] FAIL b2b%0d_byte got %h want %h", f, byte_a, b2b[f]); else passed++;
    end
    repeat (2 * CPB_A) @(negedge clock);
  endtask

  task automatic test_glitch();
    send_frame(8'h42, 1'b1, CPB_A, 1'b0);
    repeat (CPB_A) @(negedge clock);
    set_line(1'b0, 1'b0);
    repeat (CPB_A / 4) @(negedge clock);
    set_line(1'b0, 1'b1);
    repeat (2 * CPB_A) @(negedge clock);
    total++; if (avail_a !== 1'b1) $display("[TB] FAIL glitch_avail got %b want 1", avail_a); else passed++;
    total++; if (byte_a !== 8'h42) $display("[TB] FAIL glitch_byte got %h want 42", byte_a); else passed++;
    total++; if (ferr_a !== 1'b0) $display("[TB] FAIL glitch_ferr got %b want 0", ferr_a); else passed++;
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, CPB_A, 1'b0);
    set_line(1'b0, 1'b1);
    repeat (2 * CPB_A) @(negedge clock);
    total++; if (ferr_a !== 1'b1) $display("[TB] FAIL ferr_set got %b want 1", ferr_a); else passed++;
    total++; if (avail_a !== 1'b0) $display("[TB] FAIL ferr_avail got %b want 0", avail_a); else passed++;
    total++; if (byte_a !== 8'h42) $display("[TB] FAIL ferr_byte got %h want 42", byte_a); else passed++;
    send_frame(8'h3C, 1'b1, CPB_A, 1'b0);
    total++; if (ferr_a !== 1'b0) $display("[TB] FAIL ferr_clear got %b want 0", ferr_a); else passed++;
    total++; if (avail_a !== 1'b1) $display("[TB] FAIL ferr_next_avail got %b want 1", avail_a); else passed++;
    total++; if (byte_a !== 8'h3C) $display("[TB] FAIL ferr_next_byte got %h want 3c", byte_a); else passed++;
    repeat (CPB_A) @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_line(1'b0, bits[i]);
      if (i < 4) repeat (CPB_A) @(negedge clock);
    end
    repeat (CPB_A / 2) @(negedge clock);
    i_reset = 1'b1;
    set_line(1'b0, 1'b1);
    repeat (2) @(negedge clock);
    i_reset = 1'b0;
    total++; if (byte_a !== 8'h00) $display("[TB] FAIL midrst_byte got %h want 00", byte_a); else passed++;
    total++; if (avail_a !== 1'b0) $display("[TB] FAIL midrst_avail got %b want 0", avail_a); else passed++;
    total++; if (ferr_a !== 1'b0) $display("[TB] FAIL midrst_ferr got %b want 0", ferr_a); else passed++;
    repeat (12 * CPB_A) @(negedge clock);
    total++; if (avail_a !== 1'b0) $display("[TB] FAIL midrst_idle_avail got %b want 0", avail_a); else passed++;
    total++; if (byte_a !== 8'h00) $display("[TB] FAIL midrst_idle_byte got %h want 00", byte_a); else passed++;
    send_frame(8'h5A, 1'b1, CPB_A, 1'b0);
    total++; if (avail_a !== 1'b1) $display("[TB] FAIL after_rst_avail got %b want 1", avail_a); else passed++;
    total++; if (byte_a !== 8'h5A) $display("[TB] FAIL after_rst_byte got %h want 5a", byte_a); else passed++;
    total++; if (ferr_a !== 1'b0) $display("[TB] FAIL after_rst_ferr got %b want 0", ferr_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_default_rate();
    test_consecutive();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
